multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Next-generation control unit for the multicycle MIPS datapath; replaces the single-cycle decoder pair.
- Moore FSM sequences each instruction over 3-5 states, drives the shared-memory/IR/PC/regfile enables and ALU control.
- Adds BNE, optional memory wait handshake and illegal-opcode flag.

Parameters:
- ALUCTRL_W, 3, width of alucontrol; codes zero-extended into the field when wider.
- USE_MEM_READY, 1, 1: memory states stall on mem_ready; 0: mem_ready ignored, treated as 1.
- EN_BNE, 1, 1: opcode 000101 decoded as BNE; 0: treated as illegal.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- op  in  6  instr[31:26] from IR
- funct  in  6  instr[5:0] from IR
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- iord  out  1  memory address select: 0 PC, 1 ALUOut
- memwrite  out  1  data memory write strobe
- irwrite  out  1  instruction register load
- regdst  out  1  1 = rd, 0 = rt
- memtoreg  out  1  1 = MDR, 0 = ALUOut
- regwrite  out  1  register file write
- alusrca  out  1  0 PC, 1 A
- alusrcb  out  2  00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
- pcsrc  out  2  00 ALUResult, 01 ALUOut, 10 jump target
- pcen  out  1  PC load enable
- alucontrol  out  ALUCTRL_W  ALU operation
- illegal_op  out  1  one-cycle pulse on undecodable opcode
- state_o  out  4  current state, debug

Behaviour:
- Clock/reset: one clock clk; reset_n asynchronous, active-low. Assertion forces state FETCH immediately, mid-instruction included. While reset_n=0: memwrite, irwrite, regwrite, pcen, illegal_op = 0; all other outputs take FETCH values (iord=0, alusrca=0, alusrcb=01, pcsrc=00, alucontrol=010). First FETCH cycle follows the first clk edge after release.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12-15 go to FETCH next cycle with all strobes 0.
- Default output values: every output not listed for a state is 0, alusrcb=00, pcsrc=00.
- Memory wait (rdy = mem_ready, or 1 when USE_MEM_READY=0):
  - FETCH: iord=0, alusrca=0, alusrcb=01, aluop add. irwrite = pcen = rdy. Stays in FETCH while !rdy; goes to DECODE when rdy.
  - MEMRD: iord=1. Stays while !rdy; goes to MEMWB when rdy.
  - MEMWR: iord=1, memwrite=1 held for the whole stall. Goes to FETCH when rdy.
- DECODE: alusrcb=11, aluop add. Next state by op:
  - 100011/101011 -> MEMADR
  - 000000 -> EXECUTE
  - 000100 -> BRANCH
  - 000101 (EN_BNE=1) -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - any other op: illegal_op=1 this cycle, next state FETCH.
- MEMADR: alusrca=1, alusrcb=10, add. Next MEMRD for lw, MEMWR for sw.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Next FETCH.
- EXECUTE: alusrca=1, alusrcb=00, aluop funct. Next ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1. Next FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01. pcen = zero for BEQ, ~zero for BNE; op sampled from IR, which is stable. Next FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add. Next ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next FETCH.
- JUMP: pcsrc=10, pcen=1. Next FETCH.
- ALU decode:
  - aluop add -> 010; sub -> 110.
  - funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Unknown funct -> 010; no flag, the write proceeds.
- Cycle counts with rdy=1: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3.
- All outputs are combinational from state plus op, funct, zero and mem_ready; no output registers.

Test Plan:
- Release reset, op=100011, mem_ready=1 -> states 0,1,2,3,4,0; irwrite=1 and pcen=1 only in the FETCH cycle; regwrite=1 with memtoreg=1 in the state-4 cycle.
- R-type with funct=101010 -> EXECUTE shows alucontrol=111, alusrca=1; ALUWB shows regdst=1, regwrite=1; 4 cycles total.
- BEQ with zero=1 -> pcen=1, pcsrc=01 in BRANCH. BNE with zero=1 -> pcen=0. BNE with zero=0 -> pcen=1. With EN_BNE=0, op 000101 -> illegal_op pulse in DECODE, then FETCH.
- sw with mem_ready low 3 cycles in MEMWR -> state_o=5 for 4 cycles, memwrite=1 throughout, then FETCH. FETCH with mem_ready low -> irwrite=0, pcen=0 until ready.
- op=111111 -> illegal_op=1 for exactly one cycle (DECODE), regwrite and memwrite never asserted, return to FETCH.
- Assert reset_n low asynchronously mid-MEMRD -> state_o=0 before the next clk edge; memwrite, irwrite, regwrite, pcen = 0 while low.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute states and drives datapath strobes.
// Latency: lw 5, sw/R-type/addi 4, beq/bne/j 3 cycles with memory ready; outputs are combinational from state.
// Backpressure: FETCH, MEMRD and MEMWR hold their state while mem_ready is low (when enabled).
module multicycle_controller #(
  parameter int ALUCTRL_W     = 3,
  parameter bit USE_MEM_READY = 1'b1,
  parameter bit EN_BNE        = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 iord,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 regwrite,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic [1:0]           pcsrc,
  output logic                 pcen,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 illegal_op,
  output logic [3:0]           state_o
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       run;
  logic       rdy;
  logic       is_bne;
  logic [2:0] alu3;
  logic [2:0] funct_alu;

  assign rdy     = USE_MEM_READY ? mem_ready : 1'b1;
  assign is_bne  = EN_BNE && (op == 6'b000101);
  assign state_o = state;

  // State register; run stays low for the first edge after reset release so that
  // the first live FETCH cycle begins at that edge rather than before it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FETCH;
      run   <= 1'b0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
    end
  end

  // R-type function field to ALU operation; unknown codes fall back to add.
  always_comb begin
    funct_alu = 3'b010;
    case (funct)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default:   funct_alu = 3'b010;
    endcase
  end

  // Next-state and Moore outputs; strobes are forced off while reset holds or has just released.
  always_comb begin
    state_nxt  = FETCH;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    pcen       = 1'b0;
    alu3       = 3'b000;
    illegal_op = 1'b0;
    case (state)
      FETCH: begin
        alusrcb   = 2'b01;
        alu3      = 3'b010;
        irwrite   = rdy;
        pcen      = rdy;
        state_nxt = rdy ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb = 2'b11;
        alu3    = 3'b010;
        case (op)
          6'b100011, 6'b101011: state_nxt = MEMADR;
          6'b000000:            state_nxt = EXECUTE;
          6'b000100:            state_nxt = BRANCH;
          6'b001000:            state_nxt = ADDIEX;
          6'b000010:            state_nxt = JUMP;
          default: begin
            if (is_bne) begin
              state_nxt = BRANCH;
            end else begin
              illegal_op = 1'b1;
              state_nxt  = FETCH;
            end
          end
        endcase
      end
      MEMADR: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        alu3      = 3'b010;
        state_nxt = (op == 6'b100011) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord      = 1'b1;
        state_nxt = rdy ? MEMWB : MEMRD;
      end
      MEMWB: begin
        memtoreg  = 1'b1;
        regwrite  = 1'b1;
        state_nxt = FETCH;
      end
      MEMWR: begin
        iord      = 1'b1;
        memwrite  = 1'b1;
        state_nxt = rdy ? FETCH : MEMWR;
      end
      EXECUTE: begin
        alusrca   = 1'b1;
        alu3      = funct_alu;
        state_nxt = ALUWB;
      end
      ALUWB: begin
        regdst    = 1'b1;
        regwrite  = 1'b1;
        state_nxt = FETCH;
      end
      BRANCH: begin
        alusrca   = 1'b1;
        alu3      = 3'b110;
        pcsrc     = 2'b01;
        pcen      = is_bne ? ~zero : zero;
        state_nxt = FETCH;
      end
      ADDIEX: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        alu3      = 3'b010;
        state_nxt = ADDIWB;
      end
      ADDIWB: begin
        regwrite  = 1'b1;
        state_nxt = FETCH;
      end
      JUMP: begin
        pcsrc     = 2'b10;
        pcen      = 1'b1;
        state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
    if (!run) begin
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      regwrite   = 1'b0;
      pcen       = 1'b0;
      illegal_op = 1'b0;
      state_nxt  = FETCH;
    end
  end

  // Zero-extend the 3-bit ALU code into the configured field width.
  always_comb begin
    alucontrol      = '0;
    alucontrol[2:0] = alu3;
  end

endmodule
